fanin_serializer: RTL and testbench
===================================

FANIN_SERIALIZER -- requirements
Module: fanin_serializer

Interface
REQ-001 Parameter: WIDTH, default 150, number of parallel capture bits (legal range 2..1024).
REQ-002 Port: clk1  input  1  single clock; all state updates on rising edge.
REQ-003 Port: rst_n  input  1  reset, asynchronous assert, active-low.
REQ-004 Port: in_word  input  WIDTH  parallel word gathered from the load-register bank.
REQ-005 Port: in_valid  input  1  in_word valid.
REQ-006 Port: in_ready  output  1  block can capture in_word.
REQ-007 Port: sdata  output  1  serial data bit.
REQ-008 Port: sout_valid  output  1  sdata valid.
REQ-009 Port: sout_ready  input  1  downstream accepts sdata.
REQ-010 Port: sout_last  output  1  marks final beat of a frame.
REQ-011 Port: frame_cnt  output  8  count of completed frames.

Function
REQ-012 States: IDLE, SHIFT, PARITY (PARITY exists only with FANIN_PARITY_EN).
REQ-013 in_ready = 1 exactly when state is IDLE; no skid buffering.
REQ-014 Capture: in_valid & in_ready at an edge -> in_word latched, beat counter = 0, state -> SHIFT.
REQ-015 Latency: sout_valid = 1 and sdata = in_word[0] on the cycle after capture; LSB first.
REQ-016 Beat accepted when sout_valid & sout_ready; next beat presented the following cycle, no bubble.
REQ-017 Stall: while sout_valid & !sout_ready, sdata, sout_last and beat counter hold.
REQ-018 Beat counter width $clog2(WIDTH); beat k carries in_word[k], k = 0..WIDTH-1.
REQ-019 Without parity: sout_last = 1 on beat WIDTH-1; its acceptance -> IDLE, frame_cnt += 1.
REQ-020 After last-beat acceptance sout_valid = 0 and in_ready = 1 in the next cycle; a new capture occurs on that cycle's edge if in_valid = 1.
REQ-021 Throughput with continuous in_valid and sout_ready: one frame per WIDTH+1 cycles (WIDTH+2 with parity).
REQ-022 frame_cnt wraps 255 -> 0 with no flag.
REQ-023 in_word changes while not in IDLE are ignored.

Reset
REQ-024 rst_n low -> state IDLE, in_ready 1, sout_valid 0, sdata 0, sout_last 0, frame_cnt 0, shift register 0.
REQ-025 Reset mid-frame aborts the frame; the partial frame is not counted and not resumed.
REQ-026 First capture is possible on the first rising clk1 edge after rst_n deasserts.

Configuration
REQ-027 Macro FANIN_PARITY_EN defined: after beat WIDTH-1 is accepted -> PARITY; one extra beat with sdata = XOR of the captured word (even parity), sout_last = 1 on this beat only; its acceptance -> IDLE, frame_cnt += 1.
REQ-028 Macro FANIN_PARITY_EN undefined: no PARITY state and no parity logic; behaviour per REQ-019.

Structure
REQ-029 Shared package fanin_ser_pkg holds the state enum type and the FRAME_CNT_W = 8 constant.
REQ-030 One sub-module, fanin_ser_shreg: WIDTH-bit load/shift-right register with load, shift and hold controls.
REQ-031 Top holds the FSM, beat counter, parity accumulator and frame_cnt.

Verification
REQ-032 Reset release, idle -> in_ready = 1, sout_valid = 0, frame_cnt = 0, sdata = 0.
REQ-033 WIDTH = 150, in_word with only bits 0 and 149 set, sout_ready tied 1 -> sdata = 1 on beats 0 and 149 only, sout_last on beat 149, frame_cnt = 1, in_ready = 1 at cycle 151 after capture.
REQ-034 Same word, sout_ready toggled 1/0 each cycle -> beat order and values unchanged, 299 cycles from first beat to last acceptance.
REQ-035 FANIN_PARITY_EN, in_word = three bits set -> parity beat 150 has sdata = 1, sout_last only on beat 150; with four bits set, parity sdata = 0.
REQ-036 rst_n pulsed low at beat 70 -> all outputs return to reset values immediately, frame_cnt unchanged at 0, next frame starts at beat 0.
REQ-037 256 back-to-back frames -> frame_cnt wraps to 0, no idle gap beyond one cycle per frame.

Source files
------------

// File: rtl/fanin_ser_pkg.sv
// Shared types and constants for the fan-in serializer.
// Optional feature macro: FANIN_PARITY_EN adds the PARITY state.
package fanin_ser_pkg;

  localparam int unsigned FRAME_CNT_W = 8;

  // Frame sequencing states; PARITY only exists when the parity beat is built in
`ifdef FANIN_PARITY_EN
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SHIFT  = 2'd1,
    PARITY = 2'd2
  } state_e;
`else
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SHIFT  = 2'd1
  } state_e;
`endif

endpackage

// File: rtl/fanin_ser_shreg.sv
// WIDTH-bit load / shift-right register feeding the serial output.
// Ports:
//   clk, rst_n    clock, async active-low reset (clears register)
//   load, ld_data load ld_data (has priority over shift)
//   shift         shift right by one, zero fill at MSB
//   q_lo          two lowest bits: current beat and next beat
module fanin_ser_shreg #(
  parameter int unsigned WIDTH = 150
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic             shift,
  input  logic [WIDTH-1:0] ld_data,
  output logic [1:0]       q_lo
);

  logic [WIDTH-1:0] q_q;
  logic [WIDTH-1:0] q_d;

  // Load wins over shift; otherwise hold
  always_comb begin
    q_d = q_q;
    if (load) begin
      q_d = ld_data;
    end else if (shift) begin
      q_d = {1'b0, q_q[WIDTH-1:1]};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q_q <= '0;
    end else begin
      q_q <= q_d;
    end
  end

  assign q_lo = q_q[1:0];

endmodule

// File: rtl/fanin_serializer.sv
// Captures a WIDTH-bit word and emits it LSB first as a valid/ready serial
// stream, one bit per beat, flagging the final beat with sout_last.
// Optional feature macro: FANIN_PARITY_EN appends one even-parity beat.
// Ports:
//   clk1, rst_n                      clock, async active-low reset
//   in_word, in_valid, in_ready      parallel capture handshake (ready only in IDLE)
//   sdata, sout_valid, sout_ready    serial output handshake
//   sout_last                        final beat of a frame
//   frame_cnt                        completed frames, wraps at 255
module fanin_serializer
  import fanin_ser_pkg::*;
#(
  parameter int unsigned WIDTH = 150
) (
  input  logic                   clk1,
  input  logic                   rst_n,
  input  logic [WIDTH-1:0]       in_word,
  input  logic                   in_valid,
  output logic                   in_ready,
  output logic                   sdata,
  output logic                   sout_valid,
  input  logic                   sout_ready,
  output logic                   sout_last,
  output logic [FRAME_CNT_W-1:0] frame_cnt
);

  localparam int unsigned CNT_W = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(WIDTH - 1);
  localparam logic [CNT_W-1:0] PRE_LAST  = CNT_W'(WIDTH - 2);

  state_e                 state_q, state_d;
  logic [CNT_W-1:0]       beat_q, beat_d;
  logic                   sdata_q, sdata_d;
  logic                   last_q, last_d;
  logic                   valid_q, valid_d;
  logic                   ready_q, ready_d;
  logic [FRAME_CNT_W-1:0] frame_q, frame_d;
`ifdef FANIN_PARITY_EN
  logic                   parity_q, parity_d;
`endif

  logic       sr_load;
  logic       sr_shift;
  logic [1:0] sr_lo;
  logic       accept;

  fanin_ser_shreg #(
    .WIDTH (WIDTH)
  ) u_shreg (
    .clk     (clk1),
    .rst_n   (rst_n),
    .load    (sr_load),
    .shift   (sr_shift),
    .ld_data (in_word),
    .q_lo    (sr_lo)
  );

  assign accept = valid_q & sout_ready;

  // Next-state, beat sequencing and registered-output precompute
  always_comb begin
    state_d  = state_q;
    beat_d   = beat_q;
    sdata_d  = sdata_q;
    last_d   = last_q;
    frame_d  = frame_q;
    sr_load  = 1'b0;
    sr_shift = 1'b0;
`ifdef FANIN_PARITY_EN
    parity_d = parity_q;
`endif

    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
          sr_load = 1'b1;
          beat_d  = '0;
          sdata_d = in_word[0];
          last_d  = 1'b0;
          state_d = SHIFT;
`ifdef FANIN_PARITY_EN
          parity_d = 1'b0;
`endif
        end
      end

      SHIFT: begin
        if (accept) begin
`ifdef FANIN_PARITY_EN
          // Fold the accepted bit into the running parity
          parity_d = parity_q ^ sdata_q;
`endif
          if (beat_q == LAST_BEAT) begin
`ifdef FANIN_PARITY_EN
            state_d = PARITY;
            sdata_d = parity_q ^ sdata_q;
            last_d  = 1'b1;
`else
            state_d = IDLE;
            sdata_d = 1'b0;
            last_d  = 1'b0;
            frame_d = frame_q + FRAME_CNT_W'(1);
`endif
          end else begin
            // sr_lo[1] is the bit that becomes LSB after this shift
            sr_shift = 1'b1;
            beat_d   = beat_q + CNT_W'(1);
            sdata_d  = sr_lo[1];
`ifdef FANIN_PARITY_EN
            last_d   = 1'b0;
`else
            last_d   = (beat_q == PRE_LAST);
`endif
          end
        end
      end

`ifdef FANIN_PARITY_EN
      PARITY: begin
        if (accept) begin
          state_d = IDLE;
          sdata_d = 1'b0;
          last_d  = 1'b0;
          frame_d = frame_q + FRAME_CNT_W'(1);
        end
      end
`endif

      default: begin
        state_d = IDLE;
      end
    endcase

    ready_d = (state_d == IDLE);
    valid_d = (state_d != IDLE);
  end

  always_ff @(posedge clk1 or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      beat_q   <= '0;
      sdata_q  <= 1'b0;
      last_q   <= 1'b0;
      valid_q  <= 1'b0;
      ready_q  <= 1'b1;
      frame_q  <= '0;
`ifdef FANIN_PARITY_EN
      parity_q <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      beat_q   <= beat_d;
      sdata_q  <= sdata_d;
      last_q   <= last_d;
      valid_q  <= valid_d;
      ready_q  <= ready_d;
      frame_q  <= frame_d;
`ifdef FANIN_PARITY_EN
      parity_q <= parity_d;
`endif
    end
  end

  assign in_ready   = ready_q;
  assign sout_valid = valid_q;
  assign sdata      = sdata_q;
  assign sout_last  = last_q;
  assign frame_cnt  = frame_q;

endmodule

// File: tb/tb_fanin_serializer.sv
// Self-checking bench for fanin_serializer (WIDTH = 150), optional FANIN_PARITY_EN.
module tb_fanin_serializer;

  localparam int W = 150;
`ifdef FANIN_PARITY_EN
  localparam int N = W + 1;
`else
  localparam int N = W;
`endif

  logic         clk1;
  logic         rst_n;
  logic [W-1:0] in_word;
  logic         in_valid;
  logic         in_ready;
  logic         sdata;
  logic         sout_valid;
  logic         sout_ready;
  logic         sout_last;
  logic [7:0]   frame_cnt;

  int checks;
  int errors;
  int exp_frames;

  fanin_serializer #(.WIDTH(W)) dut (
    .clk1       (clk1),
    .rst_n      (rst_n),
    .in_word    (in_word),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .sdata      (sdata),
    .sout_valid (sout_valid),
    .sout_ready (sout_ready),
    .sout_last  (sout_last),
    .frame_cnt  (frame_cnt)
  );

  initial clk1 = 1'b0;
  always #5 clk1 = ~clk1;

  // Expected bit of beat k: data bits LSB first, then even parity of the word
  function automatic logic exp_bit(input logic [W-1:0] w, input int k);
    if (k < W) return w[k];
    return ^w;
  endfunction

  function automatic logic [W-1:0] rand_word();
    logic [W-1:0] w;
    for (int i = 0; i < W; i++) w[i] = 1'($urandom_range(0, 1));
    return w;
  endfunction

  // Send one frame; called and returns just after a falling edge.
  // mode 0: ready always, 1: ready toggles 1/0, 2: random ready
  task automatic send_frame(input logic [W-1:0] w, input int mode, output int cycles);
    int  k;
    bit  done;
    logic rdy;
    logic el;
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL start_ready in_ready=%b exp=1", in_ready);
    end
    in_word  = w;
    in_valid = 1'b1;
    @(negedge clk1);
    in_valid = 1'b0;
    in_word  = ~w;
    k = 0;
    cycles = 0;
    done = 1'b0;
    while (!done) begin
      if (cycles > 4 * N + 20) begin
        errors++;
        $display("FAIL frame_timeout beats=%0d exp=%0d", k, N);
        break;
      end
      el = (k == N - 1);
      checks++;
      if (sout_valid !== 1'b1 || sdata !== exp_bit(w, k) || sout_last !== el) begin
        errors++;
        $display("FAIL beat k=%0d valid=%b sdata=%b last=%b exp valid=1 sdata=%b last=%b",
                 k, sout_valid, sdata, sout_last, exp_bit(w, k), el);
      end
      case (mode)
        0:       rdy = 1'b1;
        1:       rdy = (cycles % 2 == 0);
        default: rdy = 1'($urandom_range(0, 1));
      endcase
      sout_ready = rdy;
      if (rdy) begin
        k++;
        if (k == N) done = 1'b1;
      end
      @(negedge clk1);
      cycles++;
    end
    sout_ready = 1'b0;
    exp_frames = (exp_frames + 1) % 256;
    checks++;
    if (in_ready !== 1'b1 || sout_valid !== 1'b0 || sout_last !== 1'b0 ||
        frame_cnt !== 8'(exp_frames)) begin
      errors++;
      $display("FAIL frame_end in_ready=%b valid=%b last=%b frame_cnt=%0d exp 1/0/0/%0d",
               in_ready, sout_valid, sout_last, frame_cnt, exp_frames);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    in_valid = 1'b0;
    sout_ready = 1'b0;
    in_word = '0;
    repeat (3) @(negedge clk1);
    rst_n = 1'b1;
    checks++;
    if (in_ready !== 1'b1 || sout_valid !== 1'b0 || sdata !== 1'b0 ||
        sout_last !== 1'b0 || frame_cnt !== 8'd0) begin
      errors++;
      $display("FAIL reset_state rdy=%b valid=%b sdata=%b last=%b cnt=%0d exp 1/0/0/0/0",
               in_ready, sout_valid, sdata, sout_last, frame_cnt);
    end
  endtask

  task automatic test_abort();
    logic [W-1:0] w;
    int c;
    w = rand_word();
    w[70] = 1'b1;
    in_word = w;
    in_valid = 1'b1;
    @(negedge clk1);
    in_valid = 1'b0;
    sout_ready = 1'b1;
    repeat (70) @(negedge clk1);
    sout_ready = 1'b0;
    checks++;
    if (sout_valid !== 1'b1 || sdata !== 1'b1) begin
      errors++;
      $display("FAIL abort_beat70 valid=%b sdata=%b exp 1/1", sout_valid, sdata);
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if (in_ready !== 1'b1 || sout_valid !== 1'b0 || sdata !== 1'b0 ||
        sout_last !== 1'b0 || frame_cnt !== 8'd0) begin
      errors++;
      $display("FAIL abort_reset rdy=%b valid=%b sdata=%b last=%b cnt=%0d exp 1/0/0/0/0",
               in_ready, sout_valid, sdata, sout_last, frame_cnt);
    end
    @(negedge clk1);
    rst_n = 1'b1;
    send_frame(rand_word(), 0, c);
  endtask

  task automatic test_two_bits();
    logic [W-1:0] w;
    int c;
    w = '0;
    w[0] = 1'b1;
    w[W-1] = 1'b1;
    send_frame(w, 0, c);
    checks++;
    if (c !== N) begin
      errors++;
      $display("FAIL two_bits_cycles got=%0d exp=%0d", c, N);
    end
  endtask

  task automatic test_toggle_ready();
    logic [W-1:0] w;
    int c;
    w = '0;
    w[0] = 1'b1;
    w[W-1] = 1'b1;
    send_frame(w, 1, c);
    checks++;
    if (c !== 2 * N - 1) begin
      errors++;
      $display("FAIL toggle_cycles got=%0d exp=%0d", c, 2 * N - 1);
    end
  endtask

  task automatic test_random();
    int c;
    for (int f = 0; f < 6; f++) send_frame(rand_word(), f % 3, c);
  endtask

`ifdef FANIN_PARITY_EN
  task automatic test_parity();
    logic [W-1:0] w;
    int c;
    w = '0;
    w[3] = 1'b1; w[77] = 1'b1; w[140] = 1'b1;
    send_frame(w, 0, c);
    w[10] = 1'b1;
    send_frame(w, 2, c);
  endtask
`endif

  task automatic test_back_to_back();
    logic [W-1:0] cur;
    int p;
    int start;
    start = exp_frames;
    cur = '0;
    for (int i = 0; i < 256 * (N + 1); i++) begin
      p = i % (N + 1);
      checks++;
      if (p == 0) begin
        if (in_ready !== 1'b1 || sout_valid !== 1'b0 || frame_cnt !== 8'(exp_frames)) begin
          errors++;
          $display("FAIL b2b_gap i=%0d rdy=%b valid=%b cnt=%0d exp 1/0/%0d",
                   i, in_ready, sout_valid, frame_cnt, exp_frames);
        end
        cur = rand_word();
        in_word = cur;
      end else begin
        if (in_ready !== 1'b0 || sout_valid !== 1'b1 || sdata !== exp_bit(cur, p - 1) ||
            sout_last !== (p == N)) begin
          errors++;
          $display("FAIL b2b_beat i=%0d k=%0d rdy=%b valid=%b sdata=%b last=%b exp 0/1/%b/%b",
                   i, p - 1, in_ready, sout_valid, sdata, sout_last,
                   exp_bit(cur, p - 1), (p == N));
        end
        in_word = ~cur;
      end
      in_valid = 1'b1;
      sout_ready = 1'b1;
      @(negedge clk1);
      if (p == N) exp_frames = (exp_frames + 1) % 256;
    end
    in_valid = 1'b0;
    sout_ready = 1'b0;
    checks++;
    if (frame_cnt !== 8'(start) || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL b2b_wrap frame_cnt=%0d rdy=%b exp %0d/1", frame_cnt, in_ready, start);
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    exp_frames = 0;
    test_reset();
    test_abort();
    test_two_bits();
    test_toggle_ready();
    test_random();
`ifdef FANIN_PARITY_EN
    test_parity();
`endif
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
